// File: rtl/pc_fetch_controller.sv
// Program-counter owner and instruction-fetch stage for the 4-stage pipeline.
// Issues req/ready fetches, holds one instruction for decode, applies redirects and fetch timeout.
module pc_fetch_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_target,
    input  logic        i_exc_valid,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_valid,
    output logic [31:0] o_if_instr,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_pc_plus4,
    output logic [31:0] o_pc,
    output logic        o_fetch_err
);

    // state    | meaning
    // ST_BOOT  | single idle cycle after reset release, redirects ignored
    // ST_FETCH | requesting whenever the decode slot is free
    // ST_HOLD  | decode stalled on a valid instruction, no requests
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic             r_if_valid;
    logic [31:0]      r_if_instr;
    logic [31:0]      r_if_pc;
    logic [31:0]      r_if_pc_plus4;
    logic [CNT_W-1:0] r_cnt;

    logic             w_req;
    logic             w_fetch_err;
    logic             w_slot_free;
    logic             w_active;
    logic             w_handshake;
    logic             w_timeout;
    logic             w_exc_take;
    logic             w_redir_take;
    logic [31:0]      w_target_aligned;
    logic [31:0]      w_pc_plus4;

    assign w_slot_free      = !r_if_valid || !i_stall;
    assign w_active         = (r_state != ST_BOOT);
    assign w_handshake      = w_req && i_imem_ready;
    assign w_timeout        = w_req && !i_imem_ready && (r_cnt == CNT_LAST);
    assign w_exc_take       = w_active && (i_exc_valid || w_timeout);
    assign w_redir_take     = w_active && i_redirect_valid && !w_exc_take;
    assign w_target_aligned = i_redirect_target & ALIGN_MASK;
    assign w_pc_plus4       = r_pc + 32'd4;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (w_exc_take || w_redir_take) begin
                    w_state_nxt = ST_FETCH;
                end else if (r_if_valid && i_stall) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_exc_take || w_redir_take || !i_stall) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // Redirect cycles never request, so a stray ready there is ignored.
    always_comb begin
        w_req       = 1'b0;
        w_fetch_err = 1'b0;
        if (r_state == ST_FETCH) begin
            w_req = w_slot_free && !i_exc_valid && !i_redirect_valid;
        end
        w_fetch_err = w_timeout && !i_exc_valid;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc          <= RESET_VECTOR & ALIGN_MASK;
            r_if_valid    <= 1'b0;
            r_if_instr    <= 32'h0000_0000;
            r_if_pc       <= 32'h0000_0000;
            r_if_pc_plus4 <= 32'h0000_0004;
            r_cnt         <= '0;
        end else if (w_exc_take) begin
            r_pc       <= EXC_VECTOR & ALIGN_MASK;
            r_if_valid <= 1'b0;
            r_cnt      <= '0;
        end else if (w_redir_take) begin
            r_pc       <= w_target_aligned;
            r_if_valid <= 1'b0;
            r_cnt      <= '0;
        end else if (w_handshake) begin
            r_if_instr    <= i_imem_rdata;
            r_if_pc       <= r_pc;
            r_if_pc_plus4 <= w_pc_plus4;
            r_if_valid    <= 1'b1;
            r_pc          <= w_pc_plus4;
            r_cnt         <= '0;
        end else begin
            if (w_req) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Decode took the held instruction and nothing replaced it.
            if (!i_stall) begin
                r_if_valid <= 1'b0;
            end
        end
    end

    assign o_imem_req    = w_req;
    assign o_imem_addr   = r_pc;
    assign o_pc          = r_pc;
    assign o_if_valid    = r_if_valid;
    assign o_if_instr    = r_if_instr;
    assign o_if_pc       = r_if_pc;
    assign o_if_pc_plus4 = r_if_pc_plus4;
    assign o_fetch_err   = w_fetch_err;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Self-checking bench for pc_fetch_controller: directed scenarios plus randomized
// traffic compared cycle by cycle against a transaction-level fetch model.
module tb_pc_fetch_controller;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR   = 32'h8000_0180;
    localparam int          TIMEOUT      = 16;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        exc_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] pc;
    logic        fetch_err;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: architectural PC, the decode slot, and the fetch-miss count.
    logic [31:0] m_pc, m_instr, m_ifpc, m_plus4;
    logic        m_valid, m_boot, m_blocked;
    int          m_miss;

    logic        e_req, e_err, e_valid;
    logic [31:0] e_pc, e_instr, e_ifpc, e_plus4;

    pc_fetch_controller #(
        .RESET_VECTOR(RESET_VECTOR),
        .EXC_VECTOR  (EXC_VECTOR),
        .TIMEOUT     (TIMEOUT)
    ) u_dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_stall          (stall),
        .i_redirect_valid (redirect_valid),
        .i_redirect_target(redirect_target),
        .i_exc_valid      (exc_valid),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_ready     (imem_ready),
        .i_imem_rdata     (imem_rdata),
        .o_if_valid       (if_valid),
        .o_if_instr       (if_instr),
        .o_if_pc          (if_pc),
        .o_if_pc_plus4    (if_pc_plus4),
        .o_pc             (pc),
        .o_fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_pc = RESET_VECTOR; m_instr = 32'h0; m_ifpc = 32'h0; m_plus4 = 32'h4;
        m_valid = 1'b0; m_boot = 1'b1; m_blocked = 1'b0; m_miss = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One cycle: drive inputs after the falling edge, publish expected outputs,
    // and advance the model to the state after the next rising edge.
    task automatic drive(input logic s, input logic rv, input logic [31:0] rt,
                         input logic ex, input logic rdy, input logic [31:0] rd,
                         input logic use_addr);
        logic [31:0] data;
        @(negedge clk);
        data = use_addr ? m_pc : rd;
        stall = s; redirect_valid = rv; redirect_target = rt;
        exc_valid = ex; imem_ready = rdy; imem_rdata = data;
        #1;
        e_pc = m_pc; e_valid = m_valid; e_instr = m_instr; e_ifpc = m_ifpc; e_plus4 = m_plus4;
        e_req = !m_boot && !ex && !rv && !m_blocked && (!m_valid || !s);
        e_err = e_req && !rdy && (m_miss == TIMEOUT - 1);
        if (!m_boot) begin
            if (ex || e_err) begin
                m_pc = EXC_VECTOR; m_valid = 1'b0; m_miss = 0; m_blocked = 1'b0;
            end else if (rv) begin
                m_pc = {rt[31:2], 2'b00}; m_valid = 1'b0; m_miss = 0; m_blocked = 1'b0;
            end else if (e_req && rdy) begin
                m_instr = data; m_ifpc = m_pc; m_plus4 = m_pc + 32'd4;
                m_valid = 1'b1; m_pc = m_pc + 32'd4; m_miss = 0; m_blocked = 1'b0;
            end else begin
                m_blocked = m_valid && s;
                if (e_req) m_miss++;
                if (!s) m_valid = 1'b0;
            end
        end
        m_boot = 1'b0;
    endtask

    task automatic test_reset();
        stall = 0; redirect_valid = 0; redirect_target = 0; exc_valid = 0;
        imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        #12;
        n_chk++;
        if ({imem_req, if_valid, fetch_err} !== 3'b000)
            $display("FAIL reset_ctrl: req/valid/err=%b required 000", {imem_req, if_valid, fetch_err});
        else n_pass++;
        n_chk++;
        if (pc !== RESET_VECTOR || imem_addr !== RESET_VECTOR)
            $display("FAIL reset_pc: pc=%h addr=%h required %h", pc, imem_addr, RESET_VECTOR);
        else n_pass++;
        n_chk++;
        if (if_instr !== 32'h0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h4)
            $display("FAIL reset_if: instr=%h pc=%h pc4=%h required 0/0/4", if_instr, if_pc, if_pc_plus4);
        else n_pass++;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 0, 0, 1, 0, 1);
            n_chk++;
            if (imem_req !== (k != 0))
                $display("FAIL seq_req: cycle %0d req=%b required %b", k, imem_req, k != 0);
            else n_pass++;
            if (k >= 1) begin
                n_chk++;
                if (imem_addr !== 32'(4 * (k - 1)))
                    $display("FAIL seq_addr: cycle %0d addr=%h required %h", k, imem_addr, 32'(4 * (k - 1)));
                else n_pass++;
            end
            n_chk++;
            if (if_valid !== (k >= 2))
                $display("FAIL seq_valid: cycle %0d valid=%b required %b", k, if_valid, k >= 2);
            else n_pass++;
            if (k >= 2) begin
                n_chk++;
                if (if_pc !== 32'(4 * (k - 2)) || if_instr !== 32'(4 * (k - 2)) || if_pc_plus4 !== 32'(4 * (k - 1)))
                    $display("FAIL seq_if: cycle %0d if_pc=%h instr=%h pc4=%h required %h", k, if_pc, if_instr, if_pc_plus4, 32'(4 * (k - 2)));
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] consumed[$];
        logic        s;
        apply_reset();
        for (int k = 0; k < 14; k++) begin
            s = (k >= 4 && k <= 6);
            drive(s, 0, 0, 0, 1, 0, 1);
            if (if_valid && !s) consumed.push_back(if_pc);
            n_chk++;
            if (imem_req !== e_req || if_valid !== e_valid || if_pc !== e_ifpc)
                $display("FAIL stall_model: cycle %0d req=%b valid=%b if_pc=%h required %b %b %h",
                         k, imem_req, if_valid, if_pc, e_req, e_valid, e_ifpc);
            else n_pass++;
            if (s) begin
                n_chk++;
                if (imem_req !== 1'b0 || if_pc !== 32'h8 || if_instr !== 32'h8 || if_valid !== 1'b1)
                    $display("FAIL stall_hold: cycle %0d req=%b if_pc=%h instr=%h required 0 8 8", k, imem_req, if_pc, if_instr);
                else n_pass++;
            end
        end
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (i >= consumed.size() || consumed[i] !== 32'(4 * i))
                $display("FAIL stall_order: slot %0d got %h required %h", i,
                         (i < consumed.size()) ? consumed[i] : 32'hFFFF_FFFF, 32'(4 * i));
            else n_pass++;
        end
    endtask

    task automatic test_redirect_stalled();
        drive(1, 0, 0, 0, 1, 0, 1);
        drive(1, 1, 32'h0000_0102, 0, 1, 32'h1234_5678, 0);
        n_chk++;
        if (imem_req !== 1'b0)
            $display("FAIL redir_req: req=%b required 0", imem_req);
        else n_pass++;
        drive(0, 0, 0, 0, 1, 0, 1);
        n_chk++;
        if (pc !== 32'h100 || imem_addr !== 32'h100 || if_valid !== 1'b0)
            $display("FAIL redir_pc: pc=%h valid=%b required 100 0", pc, if_valid);
        else n_pass++;
        drive(0, 0, 0, 0, 1, 0, 1);
        n_chk++;
        if (if_pc !== 32'h100 || if_valid !== 1'b1 || pc !== 32'h104)
            $display("FAIL redir_if: if_pc=%h valid=%b pc=%h required 100 1 104", if_pc, if_valid, pc);
        else n_pass++;
    endtask

    task automatic test_exc_priority();
        drive(0, 1, 32'h40, 1, 1, 0, 1);
        n_chk++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b0)
            $display("FAIL exc_cycle: err=%b req=%b required 0 0", fetch_err, imem_req);
        else n_pass++;
        drive(0, 0, 0, 0, 0, 0, 1);
        n_chk++;
        if (pc !== EXC_VECTOR || if_valid !== 1'b0)
            $display("FAIL exc_pc: pc=%h valid=%b required %h 0", pc, if_valid, EXC_VECTOR);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int pulses;
        int pulse_at;
        drive(0, 1, 32'h200, 0, 0, 0, 1);
        pulses = 0; pulse_at = -1;
        for (int k = 1; k <= TIMEOUT; k++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            if (fetch_err === 1'b1) begin pulses++; pulse_at = k; end
            n_chk++;
            if (imem_req !== 1'b1 || pc !== 32'h200)
                $display("FAIL tmo_req: cycle %0d req=%b pc=%h required 1 200", k, imem_req, pc);
            else n_pass++;
        end
        n_chk++;
        if (pulses !== 1 || pulse_at !== TIMEOUT)
            $display("FAIL tmo_pulse: pulses=%0d at=%0d required 1 at %0d", pulses, pulse_at, TIMEOUT);
        else n_pass++;
        drive(0, 0, 0, 0, 1, 0, 1);
        n_chk++;
        if (pc !== EXC_VECTOR || fetch_err !== 1'b0)
            $display("FAIL tmo_vector: pc=%h err=%b required %h 0", pc, fetch_err, EXC_VECTOR);
        else n_pass++;
        drive(0, 0, 0, 0, 1, 0, 1);
        n_chk++;
        if (if_valid !== 1'b1 || if_pc !== EXC_VECTOR || pc !== EXC_VECTOR + 32'd4)
            $display("FAIL tmo_resume: valid=%b if_pc=%h pc=%h required 1 %h", if_valid, if_pc, pc, EXC_VECTOR);
        else n_pass++;
    endtask

    task automatic test_wrap();
        drive(0, 1, 32'hFFFF_FFFF, 0, 1, 0, 1);
        drive(0, 0, 0, 0, 1, 32'hCAFE_0001, 0);
        n_chk++;
        if (pc !== 32'hFFFF_FFFC || imem_req !== 1'b1)
            $display("FAIL wrap_pc: pc=%h req=%b required fffffffc 1", pc, imem_req);
        else n_pass++;
        drive(0, 0, 0, 0, 1, 0, 1);
        n_chk++;
        if (if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0 || imem_addr !== 32'h0 || if_instr !== 32'hCAFE_0001)
            $display("FAIL wrap_next: if_pc=%h pc4=%h addr=%h instr=%h required fffffffc 0 0 cafe0001",
                     if_pc, if_pc_plus4, imem_addr, if_instr);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 0, 0, 1, 0, 1);
        n_chk++;
        if (imem_req !== 1'b1 || if_valid !== 1'b1)
            $display("FAIL rstmid_pre: req=%b valid=%b required 1 1", imem_req, if_valid);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || pc !== RESET_VECTOR)
            $display("FAIL rstmid_async: req=%b valid=%b pc=%h required 0 0 %h", imem_req, if_valid, pc, RESET_VECTOR);
        else n_pass++;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 1);
        n_chk++;
        if (imem_req !== 1'b0)
            $display("FAIL rstmid_boot: req=%b required 0", imem_req);
        else n_pass++;
    endtask

    task automatic test_random();
        logic        s, rv, ex, rdy;
        logic [31:0] rt;
        apply_reset();
        for (int k = 0; k < 600; k++) begin
            s   = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 15) == 0);
            ex  = ($urandom_range(0, 31) == 0);
            rdy = (k % 100 > 75) ? 1'b0 : ($urandom_range(0, 9) < 7);
            rt  = $urandom;
            drive(s, rv, rt, ex, rdy, $urandom, 0);
            n_chk++;
            if ({imem_req, fetch_err, if_valid} !== {e_req, e_err, e_valid})
                $display("FAIL rand_ctrl: cycle %0d req/err/valid=%b required %b", k,
                         {imem_req, fetch_err, if_valid}, {e_req, e_err, e_valid});
            else n_pass++;
            n_chk++;
            if (pc !== e_pc || imem_addr !== e_pc)
                $display("FAIL rand_pc: cycle %0d pc=%h addr=%h required %h", k, pc, imem_addr, e_pc);
            else n_pass++;
            n_chk++;
            if (if_instr !== e_instr || if_pc !== e_ifpc || if_pc_plus4 !== e_plus4)
                $display("FAIL rand_if: cycle %0d instr=%h pc=%h pc4=%h required %h %h %h", k,
                         if_instr, if_pc, if_pc_plus4, e_instr, e_ifpc, e_plus4);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stalled();
        test_exc_priority();
        test_timeout();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
